// File: rtl/data_ram_resp.sv
// Word-only data-memory responder with configurable access latency (request/ready/ack).
// Optional per-word even parity with a test flip input when RAM_PARITY_EN is defined.
module data_ram_resp #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic                  ram_w_request_i,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
`ifdef RAM_PARITY_EN
    input  logic                  par_flip_i,
`endif
    output logic                  ready_o,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  err_o
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [3:0]              r_cnt;
    logic [ADDR_WIDTH-3:0]   r_wordIdx;
    logic                    r_we;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_ack;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [IDX_W-1:0]        w_idx;
    logic                    w_inRange;
    logic                    w_accept;
    logic                    w_access;
    logic                    w_memWe;
    logic                    w_accessErr;

    assign w_idx    = r_wordIdx[IDX_W-1:0];
    assign w_accept = (r_state == ST_IDLE) && req_i;
    assign w_access = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_memWe  = w_access && r_we && w_inRange;

    // Word index beyond the array only when some bit above the array index is set.
    generate
        if (ADDR_WIDTH - 2 > IDX_W) begin : g_rangeCheck
            assign w_inRange = ~|r_wordIdx[ADDR_WIDTH-3:IDX_W];
        end else begin : g_noRangeCheck
            assign w_inRange = 1'b1;
        end
    endgenerate

`ifdef RAM_PARITY_EN
    logic r_par [DEPTH];

    always_ff @(posedge clk_i) begin
        if (w_memWe) begin
            r_par[w_idx] <= (^r_wdata) ^ par_flip_i;
        end
    end

    assign w_accessErr = !w_inRange ||
                         (!r_we && (r_par[w_idx] != (^r_mem[w_idx])));
`else
    assign w_accessErr = !w_inRange;
`endif

    // Array is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (w_memWe) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (req_i)                w_nextState = ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd0)        w_nextState = ST_RESP;
            ST_RESP:                           w_nextState = ST_IDLE;
            default:                           w_nextState = ST_IDLE;
        endcase
    end

    // ack and err are only ever high for the single RESP cycle after the access edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt     <= '0;
            r_wordIdx <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_ack <= w_access;
            r_err <= w_access && w_accessErr;
            if (w_accept) begin
                r_wordIdx <= ram_addr_i[ADDR_WIDTH-1:2];
                r_we      <= ram_w_request_i;
                r_wdata   <= ram_data_i;
                r_cnt     <= 4'(WAIT_CYCLES);
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                if (!w_inRange) begin
                    r_rdata <= '0;
                end else if (r_we) begin
                    r_rdata <= r_wdata;
                end else begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    assign ready_o    = (r_state == ST_IDLE);
    assign ack_o      = r_ack;
    assign ram_data_o = r_rdata;
    assign err_o      = r_err;

endmodule

// File: tb/tb_data_ram_resp.sv
// Scoreboard bench for data_ram_resp: a driver pushes expected responses, a monitor
// pops and compares them on every ack, including the cycle the ack arrives in.
module tb_data_ram_resp;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W  = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            ackCyc;
        string         name;
    } exp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] expData;
        logic          expErr;
        string         name;
    } vec_t;

    logic          clk;
    logic          rstN;
    logic          req;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic          parFlip;
    logic          ready;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          err;

    int   nChecks;
    int   nPass;
    int   cyc;
    exp_t expQ[$];

    data_ram_resp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (1024),
        .WAIT_CYCLES(W)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rstN),
        .req_i          (req),
        .ram_addr_i     (addr),
        .ram_w_request_i(we),
        .ram_data_i     (wdata),
`ifdef RAM_PARITY_EN
        .par_flip_i     (parFlip),
`endif
        .ready_o        (ready),
        .ack_o          (ack),
        .ram_data_o     (rdata),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedAck", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput({e.name, ".data"}, 64'(rdata), 64'(e.data));
                checkOutput({e.name, ".err"}, 64'(err), 64'(e.err));
                checkOutput({e.name, ".ackCycle"}, 64'(cyc), 64'(e.ackCyc));
            end
        end
    end

    task automatic waitReady(input string name);
        int guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (ready !== 1'b1) checkOutput({name, ".readyTimeout"}, 64'd0, 64'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int lowCnt;
        exp_t e;
        @(negedge clk);
        waitReady(v.name);
        req   = 1'b1;
        we    = v.we;
        addr  = v.addr;
        wdata = v.wdata;
        e.data   = v.expData;
        e.err    = v.expErr;
        e.ackCyc = cyc + W + 2;
        e.name   = v.name;
        expQ.push_back(e);
        @(negedge clk);
        req   = 1'b0;
        we    = ~v.we;
        addr  = ~v.addr;
        wdata = ~v.wdata;
        lowCnt = 0;
        while (ready !== 1'b1 && lowCnt < 50) begin
            lowCnt++;
            @(negedge clk);
        end
        checkOutput({v.name, ".readyLowCycles"}, 64'(lowCnt), 64'(W + 2));
    endtask

    vec_t vecs[$];

    initial begin
        nChecks = 0;
        nPass   = 0;
        cyc     = 0;
        rstN    = 1'b0;
        req     = 1'b0;
        addr    = '0;
        we      = 1'b0;
        wdata   = '0;
        parFlip = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("resetReady", 64'(ready), 64'd1);
        checkOutput("resetAck", 64'(ack), 64'd0);
        checkOutput("resetData", 64'(rdata), 64'd0);
        checkOutput("resetErr", 64'(err), 64'd0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("postResetReady", 64'(ready), 64'd1);

        vecs.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "wr10"});
        vecs.push_back('{1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, "rd10"});
        vecs.push_back('{1'b1, 32'h10,   32'h12345678, 32'h12345678, 1'b0, "wr10b"});
        vecs.push_back('{1'b0, 32'h13,   32'h0,        32'h12345678, 1'b0, "rd13"});
        vecs.push_back('{1'b1, 32'h0,    32'hCAFEF00D, 32'hCAFEF00D, 1'b0, "wr0"});
        vecs.push_back('{1'b1, 32'h1000, 32'hFFFFFFFF, 32'h0,        1'b1, "wrOor"});
        vecs.push_back('{1'b0, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0, "rd0"});
        vecs.push_back('{1'b1, 32'hFFC,  32'h0BADC0DE, 32'h0BADC0DE, 1'b0, "wrLast"});
        vecs.push_back('{1'b0, 32'hFFC,  32'h0,        32'h0BADC0DE, 1'b0, "rdLast"});
        vecs.push_back('{1'b0, 32'h1004, 32'h0,        32'h0,        1'b1, "rdOor"});
        vecs.push_back('{1'b1, 32'h20,   32'h11111111, 32'h11111111, 1'b0, "wr20"});
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Abort a pending write with reset while it is still waiting.
        @(negedge clk);
        waitReady("midReset");
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h20;
        wdata = 32'hA5A5A5A5;
        @(negedge clk);
        req  = 1'b0;
        rstN = 1'b0;
        #1;
        checkOutput("midResetReady", 64'(ready), 64'd1);
        checkOutput("midResetAck", 64'(ack), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("midResetData", 64'(rdata), 64'd0);
        applyStimulus('{1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, "rd20AfterReset"});

`ifdef RAM_PARITY_EN
        parFlip = 1'b1;
        applyStimulus('{1'b1, 32'h40, 32'h00000001, 32'h00000001, 1'b0, "wrParFlip"});
        parFlip = 1'b0;
        applyStimulus('{1'b0, 32'h40, 32'h0, 32'h00000001, 1'b1, "rdParErr"});
        applyStimulus('{1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, "rdParOk"});
`endif

        repeat (6) @(negedge clk);
        checkOutput("queueDrained", 64'(expQ.size()), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
- Data-memory responder on the far side of the MEM-stage RAM port.
- Accepts one word request at a time: address, write request, word write data. Sub-word merge and extraction stay in the MEM stage; this block is word-only.
- Models configurable access latency via a request/ready/ack handshake, so the pipeline can stall on memory instead of assuming single-cycle RAM.
- Holds a DEPTH-word synchronous array and flags out-of-range accesses.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width
DEPTH, 1024, number of words; power of two, at least 2
WAIT_CYCLES, 2, extra cycles between request accept and array access; range 0..15

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
req_i  in  1  request valid
ram_addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored
ram_w_request_i  in  1  1 = write, 0 = read
ram_data_i  in  DATA_WIDTH  full write word, already merged by the requester
ready_o  out  1  block can accept a request this cycle
ack_o  out  1  one-cycle completion pulse
ram_data_o  out  DATA_WIDTH  read data, or written word on writes; valid while ack_o=1
err_o  out  1  out-of-range flag; valid while ack_o=1

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values: state IDLE, wait counter 0, ack_o 0, ram_data_o 0, err_o 0, latched request cleared. Array contents are not reset.
- ready_o is combinational and equals (state==IDLE). It is therefore 1 during reset.
- Word index: idx = ram_addr_i[ADDR_WIDTH-1:2]. In range iff idx < DEPTH. The array is addressed with idx[log2(DEPTH)-1:0].
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_i=1 at edge E0 latches addr, we and wdata, loads cnt=WAIT_CYCLES, and moves to WAIT. req_i=0 stays in IDLE.
  - WAIT, cnt!=0: cnt decrements.
  - WAIT, cnt==0 (the access edge):
    - In-range write: array[idx] <= wdata; ram_data_o <= wdata.
    - In-range read: ram_data_o <= array[idx].
    - Out-of-range: no write; ram_data_o <= 0; err_o <= 1.
    - Then ack_o <= 1 and state moves to RESP.
  - RESP: ack_o, ram_data_o and err_o are visible for exactly this one cycle. Next edge: ack_o <= 0, err_o <= 0, state IDLE. ram_data_o holds its value until the next ack.
- Latency: request accepted at edge E0; ack_o is high in the cycle after edge E0+WAIT_CYCLES+1.
- Throughput: one request per WAIT_CYCLES+3 cycles.
- Inputs are sampled only at the accept edge. Input changes after accept are ignored.
- req_i is ignored while ready_o=0. The requester holds req_i until it sees ready_o=1.
- Read-after-write to the same word in back-to-back requests returns the new data.
- Reset mid-operation: the block returns to IDLE immediately.
  - If reset asserts before the access edge, the pending write is not performed.
  - A write completed at an earlier edge persists.
- Counter width: 4 bits.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on the write data at the access edge.
  - On an in-range read, stored parity is compared against recomputed parity. A mismatch sets err_o=1 in the ack cycle; ram_data_o still returns the stored data.
  - Adds input port par_flip_i (1 bit, test only). When 1 at a write access edge, the inverted parity is stored.
- Undefined: no parity storage, no par_flip_i port; err_o reflects only out-of-range.

Test Plan:
- Reset release: rst_n_i low then high -> ready_o=1, ack_o=0, ram_data_o=0, err_o=0.
- WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x10 at E0, then read 0x10 -> write ack_o high after edge E0+3 with ram_data_o=0xDEADBEEF. The read returns 0xDEADBEEF with err_o=0. ready_o is low for 4 cycles per request.
- WAIT_CYCLES=0: read addr 0x13 after writing 0x12345678 to 0x10 -> 0x12345678 returned (offset ignored), ack_o high after edge E0+1.
- Out of range, DEPTH=1024: write 0xFFFFFFFF to addr 0x1000 -> err_o=1, ram_data_o=0 in the ack cycle. A subsequent read of 0x0 is unchanged.
- Reset mid-op: write 0xA5A5A5A5 to 0x20 and assert rst_n_i low during WAIT -> no ack. After reset, a read of 0x20 returns the prior content.
- RAM_PARITY_EN: write 0x00000001 to 0x40 with par_flip_i=1, then read 0x40 -> ram_data_o=0x00000001, err_o=1.
